// File: rtl/mac_dot_seq.sv
// Dot-product sequencer for the grouped mac array: splits a job into 64-lane beats,
// picks each beat's group configuration, masks tail lanes and accumulates returned group sums.
module mac_dot_seq #(
    parameter int MAX_MACS          = 64,
    parameter int DATA_WIDTH        = 8,
    parameter int MAX_GROUPS        = 8,
    parameter int MAC_BIT_PER_GROUP = 6,
    parameter int LEN_WIDTH         = 16,
    parameter int ACC_WIDTH         = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,

    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [LEN_WIDTH-1:0]                    cmd_len,

    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [MAX_MACS*DATA_WIDTH-1:0]          in_data,
    input  logic [MAX_MACS*DATA_WIDTH-1:0]          in_weight,

    output logic                                    res_valid,
    input  logic                                    res_ready,
    output logic [ACC_WIDTH-1:0]                    res_data,

    output logic                                    mac_valid_in,
    output logic [$clog2(MAX_GROUPS+1)-1:0]         mac_num_groups,
    output logic [MAX_GROUPS*MAC_BIT_PER_GROUP-1:0] mac_num_macs,
    output logic [MAX_MACS*DATA_WIDTH-1:0]          mac_data,
    output logic [MAX_MACS*DATA_WIDTH-1:0]          mac_weight,
    input  logic [MAX_GROUPS*4*DATA_WIDTH-1:0]      mac_out_i,
    input  logic                                    mac_valid_out_i,

    output logic                                    busy
);

    localparam int LANE_BITS = $clog2(MAX_MACS);
    localparam int CNT_W     = LANE_BITS + 1;
    localparam int BEAT_W    = LEN_WIDTH - LANE_BITS + 1;
    localparam int HALF      = MAX_MACS / 2;
    localparam int NG_W      = $clog2(MAX_GROUPS + 1);
    localparam int CFG_W     = MAX_GROUPS * MAC_BIT_PER_GROUP;
    localparam int SUM_W     = 4 * DATA_WIDTH;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ISSUE     = 3'd1;
    localparam logic [2:0] CFG_DRAIN = 3'd2;
    localparam logic [2:0] WAIT      = 3'd3;
    localparam logic [2:0] RESULT    = 3'd4;

    logic [2:0]           state;
    logic [BEAT_W-1:0]    beats_left;
    logic [CNT_W-1:0]     tail;
    logic [ACC_WIDTH-1:0] acc;
    logic [2:0]           inflight;
    logic [NG_W-1:0]      cfg_groups;
    logic [CFG_W-1:0]     cfg_macs;

    logic [BEAT_W-1:0]    len_beats;
    logic [CNT_W-1:0]     len_tail;
    logic [CNT_W-1:0]     beat_lanes;
    logic [CNT_W-1:0]     grp0_lanes;
    logic [CNT_W-1:0]     grp1_lanes;
    logic [NG_W-1:0]      next_groups;
    logic [CFG_W-1:0]     next_macs;
    logic                 cfg_match;
    logic                 issue_ok;
    logic                 issue;
    logic                 ret_ok;
    logic                 drained;

    logic signed [SUM_W-1:0] sum0;
    logic signed [SUM_W-1:0] sum1;
    logic [ACC_WIDTH-1:0]    ret_sum;
    logic                    unused_mac_out;

    assign len_beats = BEAT_W'(cmd_len >> LANE_BITS) + BEAT_W'(cmd_len[LANE_BITS-1:0] != '0);
    assign len_tail  = (cmd_len[LANE_BITS-1:0] == '0) ? CNT_W'(MAX_MACS)
                                                      : {1'b0, cmd_len[LANE_BITS-1:0]};

    // Only the final beat of a job can be partial; every other beat uses all lanes.
    assign beat_lanes = (beats_left == BEAT_W'(1)) ? tail : CNT_W'(MAX_MACS);
    assign grp0_lanes = (beat_lanes > CNT_W'(HALF)) ? CNT_W'(HALF) : beat_lanes;
    assign grp1_lanes = beat_lanes - grp0_lanes;

    // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        next_macs = '0;
        next_macs[MAC_BIT_PER_GROUP-1:0]                   = MAC_BIT_PER_GROUP'(grp0_lanes);
        next_macs[2*MAC_BIT_PER_GROUP-1:MAC_BIT_PER_GROUP] = MAC_BIT_PER_GROUP'(grp1_lanes);
        next_groups = (grp1_lanes != '0) ? NG_W'(2) : NG_W'(1);
    end

    always_comb begin
        mac_data   = '0;
        mac_weight = '0;
        for (int i = 0; i < MAX_MACS; i++) begin
            if (CNT_W'(i) < beat_lanes) begin
                mac_data[i*DATA_WIDTH +: DATA_WIDTH]   = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                mac_weight[i*DATA_WIDTH +: DATA_WIDTH] = in_weight[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The mac reads group counts late, so a new config may only go out once nothing is in flight.
    assign cfg_match    = (next_groups == cfg_groups) && (next_macs == cfg_macs);
    assign issue_ok     = (state == ISSUE) && (cfg_match || (inflight == '0));
    assign in_ready     = issue_ok && in_valid;
    assign mac_valid_in = in_ready;
    assign issue        = in_ready;

    assign ret_ok  = mac_valid_out_i && (inflight != '0);
    assign drained = (inflight == '0) || ((inflight == 3'd1) && mac_valid_out_i);

    assign sum0    = mac_out_i[SUM_W-1:0];
    assign sum1    = mac_out_i[2*SUM_W-1:SUM_W];
    assign ret_sum = ACC_WIDTH'(sum0) + ((cfg_groups == NG_W'(2)) ? ACC_WIDTH'(sum1) : '0);
    assign unused_mac_out = ^mac_out_i[MAX_GROUPS*SUM_W-1:2*SUM_W];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            beats_left <= '0;
            tail       <= '0;
            acc        <= '0;
            inflight   <= '0;
            cfg_groups <= '0;
            cfg_macs   <= '0;
        end else begin
            case ({issue, ret_ok})
                2'b10:   inflight <= inflight + 3'd1;
                2'b01:   inflight <= inflight - 3'd1;
                default: inflight <= inflight;
            endcase

            if (ret_ok) begin
                acc <= acc + ret_sum;
            end

            if (issue) begin
                beats_left <= beats_left - BEAT_W'(1);
                cfg_groups <= next_groups;
                cfg_macs   <= next_macs;
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        beats_left <= len_beats;
                        tail       <= len_tail;
                        acc        <= '0;
                        state      <= (cmd_len == '0) ? RESULT : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue && (beats_left == BEAT_W'(1))) begin
                        state <= WAIT;
                    end else if (!issue_ok) begin
                        state <= CFG_DRAIN;
                    end
                end
                CFG_DRAIN: begin
                    if (drained) begin
                        cfg_groups <= next_groups;
                        cfg_macs   <= next_macs;
                        state      <= ISSUE;
                    end
                end
                WAIT: begin
                    if (drained) begin
                        state <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready      = (state == IDLE);
    assign busy           = (state != IDLE);
    assign res_valid      = (state == RESULT);
    assign res_data       = acc;
    assign mac_num_groups = cfg_groups;
    assign mac_num_macs   = cfg_macs;

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural two-stage mac model
// returning group sums two edges after each accepted beat.
module tb_mac_dot_seq;

    localparam int MAX_MACS   = 64;
    localparam int DW         = 8;
    localparam int MAX_GROUPS = 8;
    localparam int MBG        = 6;
    localparam int LEN_WIDTH  = 16;
    localparam int ACC_WIDTH  = 32;
    localparam int VW         = MAX_MACS * DW;
    localparam int NGW        = $clog2(MAX_GROUPS + 1);
    localparam int CW         = MAX_GROUPS * MBG;
    localparam int OW         = MAX_GROUPS * 4 * DW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [VW-1:0]        in_data;
    logic [VW-1:0]        in_weight;
    logic                 res_valid;
    logic                 res_ready;
    logic [ACC_WIDTH-1:0] res_data;
    logic                 mac_valid_in;
    logic [NGW-1:0]       mac_num_groups;
    logic [CW-1:0]        mac_num_macs;
    logic [VW-1:0]        mac_data;
    logic [VW-1:0]        mac_weight;
    logic [OW-1:0]        mac_out_i = '0;
    logic                 mac_valid_out_i = 1'b0;
    logic                 busy;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    mac_dot_seq #(
        .MAX_MACS(MAX_MACS), .DATA_WIDTH(DW), .MAX_GROUPS(MAX_GROUPS),
        .MAC_BIT_PER_GROUP(MBG), .LEN_WIDTH(LEN_WIDTH), .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .mac_valid_in(mac_valid_in), .mac_num_groups(mac_num_groups), .mac_num_macs(mac_num_macs),
        .mac_data(mac_data), .mac_weight(mac_weight),
        .mac_out_i(mac_out_i), .mac_valid_out_i(mac_valid_out_i),
        .busy(busy)
    );

    // mac model: unused group slots carry junk so a wrongly counted slot corrupts the result.
    function automatic logic [OW-1:0] group_sums(input logic [VW-1:0] d, input logic [VW-1:0] w,
                                                 input logic [CW-1:0] cfg, input logic [NGW-1:0] ng);
        logic [OW-1:0] r;
        int lane;
        int n;
        int s;
        r = '0;
        lane = 0;
        for (int g = 0; g < MAX_GROUPS; g++) begin
            n = int'(cfg[g*MBG +: MBG]);
            s = 0;
            for (int k = 0; k < n; k++) begin
                if (lane + k < MAX_MACS)
                    s += int'($signed(d[(lane+k)*DW +: DW])) * int'($signed(w[(lane+k)*DW +: DW]));
            end
            lane += n;
            r[g*32 +: 32] = (g < int'(ng)) ? s : 32'h0000_5A5A;
        end
        return r;
    endfunction

    logic          s1_v = 1'b0, s2_v = 1'b0;
    logic [VW-1:0] s1_d = '0, s1_w = '0, s2_d = '0, s2_w = '0;

    always @(posedge clk) begin
        s1_v <= mac_valid_in;
        s1_d <= mac_data;
        s1_w <= mac_weight;
        s2_v <= s1_v;
        s2_d <= s1_d;
        s2_w <= s1_w;
        mac_valid_out_i <= s2_v;
        mac_out_i       <= group_sums(s2_d, s2_w, mac_num_macs, mac_num_groups);
    end

    always @(posedge clk) begin
        if (in_ready || mac_valid_in) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input int gap, output int stall, output logic [VW-1:0] sd, output logic [VW-1:0] sw);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        #1;
        stall = 0;
        while (!in_ready && stall < 40) begin
            @(negedge clk);
            #1;
            stall++;
        end
        check("beat_accept", in_ready, 1);
        sd = mac_data;
        sw = mac_weight;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_res(output int cycles);
        cycles = 0;
        #1;
        while (!res_valid && cycles < 40) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        check("res_valid_timeout", res_valid, 1);
    endtask

    task automatic start_job(input int len);
        cmd_len   = LEN_WIDTH'(len);
        cmd_valid = 1'b1;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_res();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        check("res_valid_dropped", res_valid, 0);
        check("cmd_ready_after", cmd_ready, 1);
        check("busy_after", busy, 0);
    endtask

    initial begin
        int stall;
        int cyc;
        int p0;
        logic [VW-1:0] sd;
        logic [VW-1:0] sw;

        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        in_valid  = 1'b1;
        in_data   = '0;
        in_weight = '0;
        res_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", $signed(res_data), 0);
        check("rst_mac_valid_in", mac_valid_in, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_num_groups", mac_num_groups, 0);
        check("rst_num_macs", mac_num_macs, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);

        // len=64, all ones: one full 32/32 beat, result after edge 4.
        in_data   = {MAX_MACS{8'd1}};
        in_weight = {MAX_MACS{8'd1}};
        start_job(64);
        #1;
        check("t64_busy", busy, 1);
        check("t64_cmd_ready_low", cmd_ready, 0);
        send_beat(0, stall, sd, sw);
        check("t64_stall", stall, 0);
        check("t64_groups", mac_num_groups, 2);
        check("t64_macs", mac_num_macs, (32 << 6) | 32);
        wait_res(cyc);
        check("t64_latency", cyc, 3);
        check("t64_res", $signed(res_data), 64);
        finish_res();

        // len=100, 2 * -3: tail beat {32,4} after a config drain, lanes 36..63 masked.
        in_data   = {MAX_MACS{8'd2}};
        in_weight = {MAX_MACS{8'hFD}};
        start_job(100);
        send_beat(0, stall, sd, sw);
        check("t100_b0_stall", stall, 0);
        check("t100_b0_macs", mac_num_macs, (32 << 6) | 32);
        send_beat(0, stall, sd, sw);
        check("t100_tail_stall_range", (stall >= 1 && stall <= 3), 1);
        check("t100_tail_groups", mac_num_groups, 2);
        check("t100_tail_macs", mac_num_macs, (4 << 6) | 32);
        check("t100_mask_data_hi", |sd[VW-1:36*DW], 0);
        check("t100_mask_weight_hi", |sw[VW-1:36*DW], 0);
        check("t100_lane35_data", sd[35*DW +: DW], 2);
        check("t100_lane35_weight", sw[35*DW +: DW], 8'hFD);
        wait_res(cyc);
        check("t100_res", $signed(res_data), -600);
        finish_res();

        // len=20, -128 * -128: single group of 20.
        in_data   = {MAX_MACS{8'h80}};
        in_weight = {MAX_MACS{8'h80}};
        start_job(20);
        send_beat(0, stall, sd, sw);
        check("t20_groups", mac_num_groups, 1);
        check("t20_macs", mac_num_macs, 20);
        wait_res(cyc);
        check("t20_latency", cyc, 3);
        check("t20_res", $signed(res_data), 327680);
        finish_res();

        // len=33, ones: config {32,1}.
        in_data   = {MAX_MACS{8'd1}};
        in_weight = {MAX_MACS{8'd1}};
        start_job(33);
        send_beat(0, stall, sd, sw);
        check("t33_groups", mac_num_groups, 2);
        check("t33_macs", mac_num_macs, (1 << 6) | 32);
        wait_res(cyc);
        check("t33_res", $signed(res_data), 33);
        finish_res();

        // len=0: immediate zero result, no beat handshake even with in_valid high.
        p0        = pulse_cnt;
        in_valid  = 1'b1;
        start_job(0);
        #1;
        check("t0_res_valid", res_valid, 1);
        check("t0_res", $signed(res_data), 0);
        check("t0_in_ready", in_ready, 0);
        finish_res();
        in_valid = 1'b0;
        check("t0_no_pulses", pulse_cnt - p0, 0);

        // len=200 with random gaps: lane i holds i-32, weight 7 -> 3*(-224) + 7*(-228) = -2268.
        for (int i = 0; i < MAX_MACS; i++) begin
            in_data[i*DW +: DW]   = 8'(i - 32);
            in_weight[i*DW +: DW] = 8'd7;
        end
        start_job(200);
        send_beat(int'($urandom_range(0, 2)), stall, sd, sw);
        send_beat(int'($urandom_range(0, 2)), stall, sd, sw);
        check("t200_b1_stall", stall, 0);
        send_beat(int'($urandom_range(0, 2)), stall, sd, sw);
        check("t200_b2_stall", stall, 0);
        send_beat(int'($urandom_range(0, 2)), stall, sd, sw);
        check("t200_tail_groups", mac_num_groups, 1);
        check("t200_tail_macs", mac_num_macs, 8);
        check("t200_mask_hi", |sd[VW-1:8*DW], 0);
        wait_res(cyc);
        cmd_valid = 1'b1;
        cmd_len   = 16'd5;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t200_hold_valid", res_valid, 1);
            check("t200_hold_res", $signed(res_data), -2268);
            check("t200_hold_cmd_ready", cmd_ready, 0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        finish_res();

        // Reset with two beats in flight; stale returns must not disturb the next job.
        in_data   = {MAX_MACS{8'd1}};
        in_weight = {MAX_MACS{8'd1}};
        start_job(256);
        send_beat(0, stall, sd, sw);
        send_beat(0, stall, sd, sw);
        check("trst_no_bubble", stall, 0);
        in_valid = 1'b1;
        rst      = 1'b0;
        #1;
        check("trst_res_valid", res_valid, 0);
        check("trst_res_data", $signed(res_data), 0);
        check("trst_mac_valid_in", mac_valid_in, 0);
        check("trst_in_ready", in_ready, 0);
        check("trst_num_groups", mac_num_groups, 0);
        check("trst_num_macs", mac_num_macs, 0);
        check("trst_busy", busy, 0);
        check("trst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        start_job(64);
        send_beat(0, stall, sd, sw);
        wait_res(cyc);
        check("trst_next_latency", cyc, 3);
        check("trst_next_res", $signed(res_data), 64);
        finish_res();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_dot_seq.md
# mac_dot_seq

Sequencer that drives the grouped `mac` array to compute long signed int8 dot products. It accepts a job command with a vector length and streams 64-lane operand beats into the array. It chooses the per-beat group configuration, masks tail lanes and tracks in-flight beats. It accumulates the returned group sums and presents one scalar result per job over a valid/ready handshake. It sits between the operand fetch/DMA stream and the `mac` instance.

## Interface
- MAX_MACS, 64, lanes per beat (must equal `mac` MAX_MACS)
- DATA_WIDTH, 8, operand width (signed)
- MAX_GROUPS, 8, `mac` group slots
- MAC_BIT_PER_GROUP, 6, bits per group count field
- LEN_WIDTH, 16, job length field width
- ACC_WIDTH, 32, accumulator/result width
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  job handshake
- cmd_len  in  LEN_WIDTH  element count of job (0 allowed)
- in_valid / in_ready  in / out  1  operand beat handshake
- in_data, in_weight  in  MAX_MACS*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- res_valid / res_ready  out / in  1  result handshake
- res_data  out  ACC_WIDTH  signed dot product
- mac_valid_in  out  1  to `mac` valid_in
- mac_num_groups  out  $clog2(MAX_GROUPS+1)  to `mac` num_groups
- mac_num_macs  out  MAX_GROUPS*MAC_BIT_PER_GROUP  to `mac` num_macs_i
- mac_data, mac_weight  out  MAX_MACS*DATA_WIDTH  masked operands to `mac`
- mac_out_i  in  MAX_GROUPS*4*DATA_WIDTH  from `mac` mac_out
- mac_valid_out_i  in  1  from `mac` valid_out
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, CFG_DRAIN, WAIT, RESULT.
- IDLE: cmd_ready=1. On cmd accept, latch beats_left=ceil(len/64) and tail=len-64*(beats_left-1), clear acc. If len=0, go to RESULT with acc=0; otherwise go to ISSUE.
- Beat config:
  - Full beat (lanes n=64): num_groups=2, group0=32, group1=32.
  - Tail beat, n<64: group0=min(n,32) and group1=n-group0. num_groups=2 if group1>0, else 1.
  - Unused group fields are 0.
  - Lanes >=n on mac_data/mac_weight are forced to 0.
- mac_num_groups and mac_num_macs are registered. They are held constant from issue until that beat returns, because `mac` reads the group counts combinationally at its sum stage.
- ISSUE:
  - in_ready = mac_valid_in = in_valid when the next beat's config equals the currently driven config, or when inflight=0. mac_data/mac_weight are combinational masked passthrough.
  - If the config differs and inflight>0, go to CFG_DRAIN. Only the first beat of a job and the tail beat can change config.
  - After the last beat is accepted, go to WAIT.
- CFG_DRAIN: in_ready=0. When inflight=0, update the config and return to ISSUE.
- inflight counter: +1 on issue, -1 on mac_valid_out_i. Returns seen while inflight=0 are ignored.
- Accumulate on each counted return: acc += group0 sum, plus group1 sum if that beat's num_groups=2. Sums are truncated to ACC_WIDTH and wrap modulo 2^ACC_WIDTH. At default widths the result cannot overflow: max |sum| = 16384*65535 < 2^31.
- WAIT: when inflight reaches 0 with the final return accumulated, go to RESULT.
- RESULT: res_valid=1 and res_data=acc, both held stable until res_ready. On handshake, go to IDLE. cmd_ready=0 in every state except IDLE.

## Timing
- Reset (async assert, sync deassert assumed upstream):
  - All state goes to IDLE; acc, inflight and beats_left clear.
  - res_valid=0, res_data=0, mac_valid_in=0, mac_num_groups=0, mac_num_macs=0, in_ready=0, busy=0, cmd_ready=1.
  - Reset mid-job discards the job. Stale `mac` returns arriving afterwards are ignored (inflight=0).
- `mac` latency: a beat sampled at edge T returns mac_valid_out_i after edge T+2. The controller samples it at edge T+3.
- Throughput: one beat per cycle in ISSUE with in_valid held high. No bubble between full beats.
- The tail beat stalls up to 2 cycles in CFG_DRAIN.
- Single-beat job: cmd at edge 0, beat at edge 1, res_valid high after edge 4.
- len=0: res_valid high the cycle after the cmd accept. in_ready is never asserted.

## Test plan
- len=64, all data=1, weight=1 -> 64 issues as 32/32, res_data=64, res_valid high 4 cycles after cmd accept.
- len=100, data=2, weight=-3 -> second beat config {32,4} with num_groups=2 after CFG_DRAIN stall; lanes 36..63 driven 0; res_data=-600.
- len=20, data=-128, weight=-128 -> num_groups=1, group0=20, res_data=327680. len=33 -> config {32,1}.
- len=0 -> res_valid after 1 cycle, res_data=0, no in_ready pulse, no mac_valid_in.
- len=200, random in_valid gaps, res_ready low 5 cycles -> result matches golden model; res_data held stable; cmd_ready stays low until handshake.
- Assert rst mid-job with 2 beats in flight -> all outputs take reset values immediately. The next job (len=64, ones) returns 64, unaffected by the stale returns.
